// File: rtl/rr_mux_arbiter_if.sv
// Bundle of requester, payload and sink handshake signals for rr_mux_arbiter.
// The arbiter connects through the slave modport; whoever drives requests
// and consumes the stream connects through the master modport.
// When RR_MUX_ARB_LOCK_EN is defined the bundle also carries lock_i.
interface rr_mux_arbiter_if #(
  parameter int DATA_W = 2
);
  logic [3:0]        req_i;
  logic [DATA_W-1:0] data0_i;
  logic [DATA_W-1:0] data1_i;
  logic [DATA_W-1:0] data2_i;
  logic [DATA_W-1:0] data3_i;
  logic              ready_i;
`ifdef RR_MUX_ARB_LOCK_EN
  logic              lock_i;
`endif
  logic [3:0]        gnt_o;
  logic [3:0]        ack_o;
  logic [1:0]        direction_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;

  modport slave (
`ifdef RR_MUX_ARB_LOCK_EN
    input  lock_i,
`endif
    input  req_i, data0_i, data1_i, data2_i, data3_i, ready_i,
    output gnt_o, ack_o, direction_o, valid_o, data_o
  );

  modport master (
`ifdef RR_MUX_ARB_LOCK_EN
    output lock_i,
`endif
    output req_i, data0_i, data1_i, data2_i, data3_i, ready_i,
    input  gnt_o, ack_o, direction_o, valid_o, data_o
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and sequencer in front of the shared 4:1 mux datapath.
// One requester owns the output channel at a time; its payload is streamed
// over valid/ready and a hold counter limits the tenure to HOLD_MAX beats.
// Optional feature macro RR_MUX_ARB_LOCK_EN: adds lock_i, which lets the
// current owner keep the channel past the hold limit while it stays high.
module rr_mux_arbiter #(
  parameter int DATA_W   = 2,
  parameter int HOLD_MAX = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  rr_mux_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [3:0]        gnt_q, gnt_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              owner_req;
  logic              valid;
  logic              beat;
  logic              lock_active;
  logic              at_limit;
  logic              rel_drop;
  logic              rel_limit;
  logic [DATA_W-1:0] data_sel;
  logic [2:0]        pick_idle;
  logic [2:0]        pick_rel;

  // Returns {found, index} of the first set request scanning start, start+1, ...
  // The loop runs backwards so the smallest offset overwrites the result last.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef RR_MUX_ARB_LOCK_EN
  assign lock_active = bus.lock_i;
`else
  assign lock_active = 1'b0;
`endif

  // Fresh arbitration from the pointer, and re-arbitration on release that
  // starts after the current owner and never considers it.
  assign pick_idle = rr_pick(bus.req_i, ptr_q);
  assign pick_rel  = rr_pick(bus.req_i & ~gnt_q, dir_q + 2'd1);

  // State register: all arbitration state clears immediately on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      dir_q   <= 2'b00;
      ptr_q   <= 2'b00;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      dir_q   <= dir_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: grant from IDLE, count beats, and hand off or re-grant on release.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    dir_d     = dir_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    at_limit  = (cnt_q == HOLD_LAST);
    rel_drop  = (state_q == GRANT) && !owner_req;
    rel_limit = beat && at_limit && !lock_active;
    case (state_q)
      IDLE: begin
        if (pick_idle[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick_idle[1:0];
          dir_d   = pick_idle[1:0];
          cnt_d   = 8'd0;
        end
      end
      GRANT: begin
        if (rel_drop || rel_limit) begin
          ptr_d = dir_q + 2'd1;
          cnt_d = 8'd0;
          if (pick_rel[2]) begin
            gnt_d = 4'b0001 << pick_rel[1:0];
            dir_d = pick_rel[1:0];
          end else if (!rel_limit) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (beat && !at_limit) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // Outputs: valid follows the owner's request, payload follows the select.
  always_comb begin
    owner_req = bus.req_i[dir_q];
    valid     = (state_q == GRANT) && owner_req;
    beat      = valid && bus.ready_i;
    case (dir_q)
      2'd0:    data_sel = bus.data0_i;
      2'd1:    data_sel = bus.data1_i;
      2'd2:    data_sel = bus.data2_i;
      default: data_sel = bus.data3_i;
    endcase
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.direction_o = dir_q;
  assign bus.valid_o     = valid;
  assign bus.ack_o       = gnt_q & {4{beat}};
  assign bus.data_o      = data_sel;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with a tenure-level reference model.
module tb_rr_mux_arbiter;
  localparam int HOLD = 4;

  typedef struct {
    int owner;
    int ptr;
    int beats;
    int last;
  } model_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ready;
  logic [1:0] data_in [4];
  logic       lock_seen;
  int         errors;
  int         checks;
  model_t     m = '{owner: -1, ptr: 0, beats: 0, last: 0};
  logic [1:0] seen_data [16];
  logic [3:0] seen_gnt  [16];
  logic [1:0] exp_seq   [16];

  rr_mux_arbiter_if #(.DATA_W(2)) bus ();

  assign bus.req_i   = req;
  assign bus.ready_i = ready;
  assign bus.data0_i = data_in[0];
  assign bus.data1_i = data_in[1];
  assign bus.data2_i = data_in[2];
  assign bus.data3_i = data_in[3];

`ifdef RR_MUX_ARB_LOCK_EN
  logic lock;
  assign bus.lock_i  = lock;
  assign lock_seen   = lock;
`else
  assign lock_seen   = 1'b0;
`endif

  rr_mux_arbiter #(.DATA_W(2), .HOLD_MAX(HOLD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock of tenure behaviour: who owns the channel, how many beats it
  // has had, and who gets it next when it lets go.
  function automatic model_t modelStep(model_t cur, logic [3:0] r, logic rdy, logic lk);
    model_t nxt;
    bit     rel;
    bit     limit;
    int     cand[$];
    nxt   = cur;
    rel   = 0;
    limit = 0;
    if (cur.owner < 0) begin
      for (int i = 0; i < 4; i++) begin
        if (nxt.owner < 0 && r[(cur.ptr + i) % 4]) begin
          nxt.owner = (cur.ptr + i) % 4;
          nxt.last  = nxt.owner;
          nxt.beats = 0;
        end
      end
    end else begin
      if (!r[cur.owner]) begin
        rel = 1;
      end else if (rdy) begin
        nxt.beats = cur.beats + 1;
        if (nxt.beats >= HOLD) begin
          if (lk) nxt.beats = HOLD - 1;
          else begin
            rel   = 1;
            limit = 1;
          end
        end
      end
      if (rel) begin
        nxt.ptr   = (cur.owner + 1) % 4;
        nxt.beats = 0;
        for (int i = 0; i < 4; i++) begin
          if (((nxt.ptr + i) % 4) != cur.owner && r[(nxt.ptr + i) % 4])
            cand.push_back((nxt.ptr + i) % 4);
        end
        if (cand.size() > 0) begin
          nxt.owner = cand[0];
          nxt.last  = cand[0];
        end else if (!limit) begin
          nxt.owner = -1;
        end
      end
    end
    return nxt;
  endfunction

  function automatic logic [3:0] expGnt(model_t cur);
    return (cur.owner < 0) ? 4'b0000 : 4'(1 << cur.owner);
  endfunction

  function automatic logic expValid(model_t cur, logic [3:0] r);
    return (cur.owner >= 0) && r[cur.owner];
  endfunction

  function automatic logic [3:0] expAck(model_t cur, logic [3:0] r, logic rdy);
    return (expValid(cur, r) && rdy) ? expGnt(cur) : 4'b0000;
  endfunction

  // Model advances on each clock edge and snaps back on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{owner: -1, ptr: 0, beats: 0, last: 0};
    else     m <= modelStep(m, req, ready, lock_seen);
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every mid-cycle the DUT outputs must match the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_gnt",   8'(bus.gnt_o),       8'(expGnt(m)));
      checkOutput("model_dir",   8'(bus.direction_o), 8'(m.last));
      checkOutput("model_valid", 8'(bus.valid_o),     8'(expValid(m, req)));
      checkOutput("model_data",  8'(bus.data_o),      8'(data_in[m.last]));
      checkOutput("model_ack",   8'(bus.ack_o),       8'(expAck(m, req, ready)));
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    @(posedge clk);
    #2;
    req   = r;
    ready = rdy;
  endtask

  task automatic midCycle;
    @(negedge clk);
    #1;
  endtask

  task automatic doReset;
    @(posedge clk);
    #2;
    rst   = 1'b1;
    req   = 4'b0000;
    ready = 1'b0;
    @(posedge clk);
    #2;
    rst   = 1'b0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    req        = 4'b0000;
    ready      = 1'b0;
    data_in[0] = 2'b11;
    data_in[1] = 2'b10;
    data_in[2] = 2'b01;
    data_in[3] = 2'b00;
`ifdef RR_MUX_ARB_LOCK_EN
    lock       = 1'b0;
`endif
    exp_seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2,
                2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

    // Reset values
    midCycle();
    checkOutput("rst_gnt",   8'(bus.gnt_o),       8'h00);
    checkOutput("rst_dir",   8'(bus.direction_o), 8'h00);
    checkOutput("rst_valid", 8'(bus.valid_o),     8'h00);
    checkOutput("rst_ack",   8'(bus.ack_o),       8'h00);
    checkOutput("rst_data",  8'(bus.data_o),      8'h03);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Ready with no request does nothing
    applyStimulus(4'b0000, 1'b1);
    for (int i = 0; i < 2; i++) begin
      midCycle();
      checkOutput("idle_ack",   8'(bus.ack_o),   8'h00);
      checkOutput("idle_valid", 8'(bus.valid_o), 8'h00);
    end

    // Single requester 0: granted next cycle, acked every cycle
    applyStimulus(4'b0001, 1'b1);
    @(posedge clk);
    midCycle();
    checkOutput("t1_gnt",  8'(bus.gnt_o),       8'h01);
    checkOutput("t1_dir",  8'(bus.direction_o), 8'h00);
    checkOutput("t1_data", 8'(bus.data_o),      8'h03);
    checkOutput("t1_ack",  8'(bus.ack_o),       8'h01);
    for (int i = 0; i < 6; i++) begin
      midCycle();
      checkOutput("t1_ack_cont", 8'(bus.ack_o), 8'h01);
    end

    // All four requesting: rotation every HOLD beats without bubbles
    doReset();
    applyStimulus(4'b1111, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      midCycle();
      seen_data[i] = bus.data_o;
      seen_gnt[i]  = bus.gnt_o;
    end
    for (int i = 0; i < 16; i++) begin
      checkOutput("t2_data_seq", 8'(seen_data[i]), 8'(exp_seq[i]));
      checkOutput("t2_gnt_seq",  8'(seen_gnt[i]),  8'(4'b1000 >> exp_seq[i]));
    end
    midCycle();
    checkOutput("t2_wrap_gnt", 8'(bus.gnt_o), 8'h01);

    // Owner 2 stalled by the sink: no beats, no handoff
    doReset();
    applyStimulus(4'b1100, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      midCycle();
      checkOutput("t3_gnt",   8'(bus.gnt_o),   8'h04);
      checkOutput("t3_valid", 8'(bus.valid_o), 8'h01);
      checkOutput("t3_data",  8'(bus.data_o),  8'h01);
      checkOutput("t3_ack",   8'(bus.ack_o),   8'h00);
    end
    applyStimulus(4'b1100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      midCycle();
      checkOutput("t3_beat_ack", 8'(bus.ack_o), 8'h04);
    end
    midCycle();
    checkOutput("t3_handoff_gnt", 8'(bus.gnt_o), 8'h08);

    // Owner 1 drops after two beats with requester 3 waiting
    doReset();
    applyStimulus(4'b0010, 1'b1);
    @(posedge clk);
    midCycle();
    checkOutput("t4_beat1_ack", 8'(bus.ack_o), 8'h02);
    midCycle();
    checkOutput("t4_beat2_ack", 8'(bus.ack_o), 8'h02);
    applyStimulus(4'b1000, 1'b1);
    midCycle();
    checkOutput("t4_drop_valid", 8'(bus.valid_o), 8'h00);
    checkOutput("t4_drop_gnt",   8'(bus.gnt_o),   8'h02);
    midCycle();
    checkOutput("t4_new_gnt",  8'(bus.gnt_o),       8'h08);
    checkOutput("t4_new_dir",  8'(bus.direction_o), 8'h03);
    checkOutput("t4_new_data", 8'(bus.data_o),      8'h00);
    checkOutput("t4_new_ack",  8'(bus.ack_o),       8'h08);

    // Reset pulse during requester 3's tenure
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_gnt",   8'(bus.gnt_o),   8'h00);
    checkOutput("t5_rst_valid", 8'(bus.valid_o), 8'h00);
    checkOutput("t5_rst_ack",   8'(bus.ack_o),   8'h00);
    @(posedge clk);
    #2;
    rst = 1'b0;
    midCycle();
    checkOutput("t5_idle_gnt", 8'(bus.gnt_o), 8'h00);
    midCycle();
    checkOutput("t5_regrant", 8'(bus.gnt_o), 8'h08);

`ifdef RR_MUX_ARB_LOCK_EN
    // Lock keeps requester 0 past the hold limit until it drops
    doReset();
    lock = 1'b1;
    applyStimulus(4'b0011, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      midCycle();
      checkOutput("t6_lock_gnt", 8'(bus.gnt_o), 8'h01);
    end
    @(posedge clk);
    #2;
    lock = 1'b0;
    midCycle();
    checkOutput("t6_beat10_ack", 8'(bus.ack_o), 8'h01);
    midCycle();
    checkOutput("t6_release_gnt", 8'(bus.gnt_o), 8'h02);
`endif

    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
